// File: rtl/uart_word_serializer_if.sv
// Word handshake plus UART transmit-side signals for uart_word_serializer.
// master = upstream/UART environment, slave = the serializer.
interface uart_word_serializer_if #(
  parameter int WORD_BYTES = 4
);
  logic                    word_valid;
  logic [8*WORD_BYTES-1:0] word_data;
  logic                    word_ready;
  logic                    busy;
  logic                    word_sent_tick;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    tx_busy;
  logic                    tx_done_tick;

  modport master (
    output word_valid, word_data, tx_busy, tx_done_tick,
    input  word_ready, busy, word_sent_tick, tx_start, tx_data
  );

  modport slave (
    input  word_valid, word_data, tx_busy, tx_done_tick,
    output word_ready, busy, word_sent_tick, tx_start, tx_data
  );
endinterface

// File: rtl/uart_word_serializer.sv
// Sends one WORD_BYTES-wide word to the UART MSB first, one byte per tx_done_tick.
// Define UART_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte to every word.
module uart_word_serializer #(
  parameter int WORD_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_word_serializer_if.slave  bus
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

`ifdef UART_SERIALIZER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHK_ISSUE, CHK_WAIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] shift_next;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              word_ready_q, word_ready_d;
  logic              word_sent_q, word_sent_d;
  logic              issue_state;
`ifdef UART_SERIALIZER_CHECKSUM_EN
  logic [7:0]        checksum_q, checksum_d;
`endif

  assign shift_next = shift_q << 8;

`ifdef UART_SERIALIZER_CHECKSUM_EN
  assign issue_state = (state_q == ISSUE) || (state_q == CHK_ISSUE);
`else
  assign issue_state = (state_q == ISSUE);
`endif

  // tx_data is preloaded on entry to ISSUE, so the strobe can fire in the
  // very cycle tx_busy is first seen low.
  assign bus.tx_start       = issue_state && !bus.tx_busy;
  assign bus.tx_data        = tx_data_q;
  assign bus.busy           = busy_q;
  assign bus.word_ready     = word_ready_q;
  assign bus.word_sent_tick = word_sent_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    tx_data_d  = tx_data_q;
`ifdef UART_SERIALIZER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.word_valid) begin
          shift_d    = bus.word_data;
          byte_cnt_d = '0;
          tx_data_d  = bus.word_data[WORD_W-1 -: 8];
`ifdef UART_SERIALIZER_CHECKSUM_EN
          checksum_d = 8'h00;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.tx_busy) begin
`ifdef UART_SERIALIZER_CHECKSUM_EN
          checksum_d = checksum_q ^ tx_data_q;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.tx_done_tick) begin
          if (byte_cnt_q == LAST_CNT) begin
`ifdef UART_SERIALIZER_CHECKSUM_EN
            tx_data_d = checksum_q;
            state_d   = CHK_ISSUE;
`else
            state_d   = DONE;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            shift_d    = shift_next;
            tx_data_d  = shift_next[WORD_W-1 -: 8];
            state_d    = ISSUE;
          end
        end
      end
`ifdef UART_SERIALIZER_CHECKSUM_EN
      CHK_ISSUE: begin
        if (!bus.tx_busy) state_d = CHK_WAIT;
      end
      CHK_WAIT: begin
        if (bus.tx_done_tick) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    word_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    word_sent_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      word_ready_q <= 1'b1;
      word_sent_q  <= 1'b0;
`ifdef UART_SERIALIZER_CHECKSUM_EN
      checksum_q   <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      word_ready_q <= word_ready_d;
      word_sent_q  <= word_sent_d;
`ifdef UART_SERIALIZER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_word_serializer.sv
// Directed bench for uart_word_serializer with a simple UART transmit model
// (done tick 10 cycles after start, tx_busy low 2 cycles after the tick).
module tb_uart_word_serializer;
  localparam int WB = 4;
`ifdef UART_SERIALIZER_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_word_serializer_if #(.WORD_BYTES(WB)) bus ();

  uart_word_serializer #(.WORD_BYTES(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic       force_busy = 1'b0;
  logic [7:0] q_data[$];
  int         q_cyc[$];
  int         sent_q[$];
  int         last_done = -1;
  logic [7:0] exp_q[$];

  int         m_elapsed = 0;
  bit         m_active = 1'b0;
  bit         m_start_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // UART transmit model and output monitor
  initial begin
    bus.tx_busy      = 1'b0;
    bus.tx_done_tick = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (m_start_prev) begin
        m_active  = 1'b1;
        m_elapsed = 1;
      end else if (m_active) begin
        m_elapsed++;
      end
      bus.tx_done_tick = m_active && (m_elapsed == 10);
      bus.tx_busy      = (m_active && (m_elapsed < 12)) || force_busy;
      if (m_active && m_elapsed >= 12) m_active = 1'b0;
      @(negedge clk);
      m_start_prev = bus.tx_start;
      if (bus.tx_start) begin
        q_data.push_back(bus.tx_data);
        q_cyc.push_back(cyc);
        $display("cycle %0d: tx byte 0x%02h", cyc, bus.tx_data);
      end
      if (bus.tx_done_tick) last_done = cyc;
      if (bus.word_sent_tick) begin
        sent_q.push_back(cyc);
        $display("cycle %0d: word_sent_tick", cyc);
      end
    end
  end

  task automatic clear_logs();
    q_data.delete();
    q_cyc.delete();
    sent_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [7:0] chk);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    if (CHK_EN != 0) exp_q.push_back(chk);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_nbytes"}, q_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_data.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), q_data[i], exp_q[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_start"}, bus.tx_start, 1'b0);
    check({tag, "_tx_data"}, bus.tx_data, 8'h00);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_sent"}, bus.word_sent_tick, 1'b0);
    check({tag, "_ready"}, bus.word_ready, 1'b1);
  endtask

  // Called one time unit after a rising edge with word_valid already driven.
  task automatic wait_accept(input string tag, output int acc);
    acc = -1;
    for (int k = 0; k < 3000 && acc < 0; k++) begin
      @(negedge clk);
      if (bus.word_ready) acc = cyc;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_accept_timeout"}, acc >= 0, 1'b1);
  endtask

  task automatic send_word(input string tag, input logic [31:0] w, output int acc);
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    wait_accept(tag, acc);
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input int target);
    int k;
    k = 0;
    while (sent_q.size() < target && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({tag, "_sent_timeout"}, sent_q.size() >= target, 1'b1);
  endtask

  initial begin
    int acc;
    int acc2;
    int nb;
    int k;

    bus.word_valid = 1'b0;
    bus.word_data  = '0;

    // reset held for 5 cycles, then released
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("rst_hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_release");
    end
    @(posedge clk);
    #1;

    // single word, MSB first, back-to-back byte spacing
    clear_logs();
    expect_word(32'hDEADBEEF, 8'h22);
    send_word("t2", 32'hDEADBEEF, acc);
    wait_sent("t2", 1);
    check_stream("t2");
    if (q_cyc.size() > 0) check("t2_first_start", q_cyc[0], acc + 1);
    for (int i = 1; i < q_cyc.size(); i++)
      check($sformatf("t2_gap%0d", i), q_cyc[i] - q_cyc[i-1], 12);
    check("t2_sent_count", sent_q.size(), 1);
    if (sent_q.size() > 0) check("t2_sent_after_done", sent_q[0], last_done + 1);
    @(negedge clk);
    check("t2_ready_after", bus.word_ready, 1'b1);
    check("t2_busy_after", bus.busy, 1'b0);
    @(posedge clk);
    #1;

    // tx_busy forced high for 20 cycles starting at acceptance
    clear_logs();
    expect_word(32'h01020304, 8'h04);
    force_busy = 1'b1;
    send_word("t3", 32'h01020304, acc);
    repeat (19) @(posedge clk);
    #1;
    force_busy = 1'b0;
    wait_sent("t3", 1);
    check_stream("t3");
    if (q_cyc.size() > 0) check("t3_first_start", q_cyc[0], acc + 20);

    // two words with word_valid held high throughout
    clear_logs();
    expect_word(32'h01020304, 8'h04);
    expect_word(32'hA5A5A5A5, 8'h00);
    bus.word_valid = 1'b1;
    bus.word_data  = 32'h01020304;
    wait_accept("t4a", acc);
    @(posedge clk);
    #1;
    bus.word_data = 32'hA5A5A5A5;
    wait_accept("t4b", acc2);
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    wait_sent("t4", 2);
    check_stream("t4");
    check("t4_sent_count", sent_q.size(), 2);
    if (sent_q.size() > 0) check("t4_second_accept", acc2, sent_q[0] + 1);

    // reset pulsed after the 2nd byte has started
    clear_logs();
    send_word("t5", 32'hDEADBEEF, acc);
    k = 0;
    while (q_data.size() < 2 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("t5_two_bytes_timeout", q_data.size() >= 2, 1'b1);
    rst = 1'b0;
    nb  = q_data.size();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    check("t5_no_more_starts", q_data.size(), nb);
    check("t5_no_sent", sent_q.size(), 0);
    @(negedge clk);
    check_idle("t5_after_rst");
    @(posedge clk);
    #1;
    clear_logs();
    expect_word(32'h11223344, 8'h44);
    send_word("t5n", 32'h11223344, acc);
    wait_sent("t5n", 1);
    check_stream("t5n");
    check("t5n_sent_count", sent_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_word_serializer.md
Name: uart_word_serializer

Overview:
- Drives the transmit side of the UART block: tx_start, tx_data, tx_busy, tx_done_tick.
- Accepts one multi-byte word from the crypter through a valid/ready handshake.
- Sends the word byte by byte, most significant byte first, and waits for each byte to complete before issuing the next.
- Pulses word_sent_tick when the whole word has gone out on the line.

Parameters:
- WORD_BYTES, 4, number of bytes per word; legal range ≥1; word width is 8*WORD_BYTES.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- word_valid  in  1  upstream has a word on word_data.
- word_data  in  8*WORD_BYTES  word to transmit; byte WORD_BYTES-1 (MSB) goes first.
- word_ready  out  1  block can accept a word (state IDLE).
- busy  out  1  high from acceptance until word_sent_tick, inclusive.
- word_sent_tick  out  1  one-cycle pulse after the last byte's tx_done_tick.
- tx_start  out  1  one-cycle pulse that launches a byte in the UART.
- tx_data  out  8  byte being transmitted; stable from tx_start until the matching tx_done_tick.
- tx_busy  in  1  UART transmit-in-progress flag; rises the cycle after tx_start and falls the cycle after tx_done_tick.
- tx_done_tick  in  1  UART pulse marking end of stop bit.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; shift register, byte counter and tx_data cleared to 0.
  - tx_start=0, busy=0, word_sent_tick=0, word_ready=1.
- Any in-flight word is discarded and never resumed.
- FSM states: IDLE, ISSUE, WAIT, [CHK_ISSUE, CHK_WAIT when the optional feature is enabled], DONE.
- IDLE:
  - word_ready=1.
  - On word_valid=1, capture word_data into the shift register, byte_cnt←0, checksum←0, then go to ISSUE.
- ISSUE:
  - While tx_busy=1, hold in ISSUE; this covers the one-cycle tail of tx_busy after a done tick.
  - When tx_busy=0: tx_start=1 for exactly this cycle, tx_data←shift register top byte, checksum^=that byte, then go to WAIT.
- WAIT:
  - On tx_done_tick, if byte_cnt==WORD_BYTES-1, go to DONE (or CHK_ISSUE if enabled).
  - Otherwise byte_cnt++, shift the register left by 8, go to ISSUE.
  - tx_done_tick seen in any state other than WAIT/CHK_WAIT is ignored.
- DONE: word_sent_tick=1 for one cycle, then go to IDLE.
- Latency:
  - Acceptance at cycle N gives the first tx_start at N+1 when tx_busy=0.
  - Each later tx_start comes ≥2 cycles after the previous tx_done_tick, because tx_busy clears one cycle after the tick.
- word_valid while word_ready=0 is ignored; upstream must hold the word.
- There is no back-to-back acceptance: the next word can be accepted at the earliest in the cycle after DONE.
- byte_cnt width is $clog2(WORD_BYTES) with a minimum of 1 bit. With WORD_BYTES=1 the block sends a single byte.

Optional Feature:
- Macro: UART_SERIALIZER_CHECKSUM_EN.
- Defined:
  - After the last data byte's tx_done_tick, go to CHK_ISSUE.
  - CHK_ISSUE sends the XOR of all data bytes using the same tx_busy/tx_start rules as ISSUE.
  - CHK_WAIT waits for tx_done_tick, then goes to DONE.
  - Total is WORD_BYTES+1 tx_start pulses per word.
- Undefined: no checksum logic or states exist; exactly WORD_BYTES bytes are sent per word.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release → tx_start=0, tx_data=0x00, busy=0, word_sent_tick=0, word_ready=1 throughout.
- Single word, WORD_BYTES=4, word_data=0xDEADBEEF, TX model gives tx_done_tick 10 cycles after each start → 4 tx_start pulses carrying 0xDE,0xAD,0xBE,0xEF. word_sent_tick fires once, one cycle after the 4th done tick; first tx_start is 1 cycle after acceptance.
- tx_busy forced high for 20 cycles at acceptance of 0x01020304 → no tx_start until the cycle tx_busy=0; then 0x01 is sent first.
- Two words, 0x01020304 then 0xA5A5A5A5, with word_valid held high → second word accepted only after word_sent_tick. Output stream is 01 02 03 04 A5 A5 A5 A5 with exactly 8 tx_start pulses.
- rst pulsed low after the 2nd byte's tx_start → no further tx_start, word_ready=1 after release. A new word 0x11223344 is then sent starting with 0x11.
- UART_SERIALIZER_CHECKSUM_EN defined, word 0xDEADBEEF → 5th byte is 0x22 and word_sent_tick follows its done tick. With the macro undefined, exactly 4 bytes are sent.
